// File: rtl/aggregate_param.sv
// aggregate_param: packs a stream of IN_W-bit beats into OUT_W-bit words and
// marks frame boundaries (a frame is a contiguous run of axiiv high).
// Each word carries a last flag and a valid-beat count, and an optional
// per-frame word cap drops the tail of a frame.
// Build option: define AGGREGATE_FLUSH_EN to emit a partial trailing word
// with its beat count. When it is undefined, that word is discarded and
// axioerr pulses instead.
module aggregate_param #(
  parameter int IN_W         = 2,
  parameter int OUT_W        = 32,
  parameter int FIRST_IN_MSB = 1,
  parameter int MAX_WORDS    = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             axiiv,
  input  logic [IN_W-1:0]                  axiid,
  output logic                             axiov,
  output logic [OUT_W-1:0]                 axiod,
  output logic                             axiolast,
  output logic [$clog2(OUT_W/IN_W+1)-1:0]  axiokeep,
  output logic                             axioerr
);

  localparam int BEATS = OUT_W / IN_W;
  localparam int KW    = $clog2(BEATS + 1);
  localparam int WC_W  = (MAX_WORDS > 0) ? $clog2(MAX_WORDS + 1) : 1;
  localparam logic [KW-1:0] LAST_IDX  = KW'(BEATS - 1);
  localparam logic [KW-1:0] FULL_KEEP = KW'(BEATS);

  // Drop a beat into its slot; the first beat of a word sits at the end
  // selected by FIRST_IN_MSB, so a partial word is already left in place.
  function automatic logic [OUT_W-1:0] place_beat(input logic [OUT_W-1:0] base,
                                                  input logic [IN_W-1:0]  beat,
                                                  input logic [KW-1:0]    idx);
    logic [OUT_W-1:0] slot;
    int               sh;
    slot = OUT_W'(beat);
    if (FIRST_IN_MSB != 0) sh = (BEATS - 1 - int'(idx)) * IN_W;
    else                   sh = int'(idx) * IN_W;
    return base | (slot << sh);
  endfunction

  logic [OUT_W-1:0] acc_p0;
  logic [KW-1:0]    bcnt_p0;
  logic [WC_W-1:0]  wcnt_p0;
  logic [OUT_W-1:0] hold_p1;
  logic             vld_p1;

  logic             capped;
  logic             take;
  logic             word_done;
  logic             emit_full;
  logic             partial;
  logic [OUT_W-1:0] acc_nxt;

  assign capped    = (MAX_WORDS > 0) && (wcnt_p0 == WC_W'(MAX_WORDS));
  assign take      = axiiv && !capped;
  assign word_done = take && (bcnt_p0 == LAST_IDX);
  assign emit_full = vld_p1 && (take || !axiiv);
  assign partial   = !axiiv && !vld_p1 && (bcnt_p0 != '0);
  assign acc_nxt   = place_beat((bcnt_p0 == '0) ? '0 : acc_p0, axiid, bcnt_p0);

  // Stage p0 -> p1: accumulate beats, hand full words to the holding register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_p0  <= '0;
      bcnt_p0 <= '0;
      wcnt_p0 <= '0;
      hold_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (take) begin
      vld_p1 <= word_done;
      if (word_done) begin
        hold_p1 <= acc_nxt;
        bcnt_p0 <= '0;
        if (MAX_WORDS > 0) wcnt_p0 <= wcnt_p0 + WC_W'(1);
      end else begin
        acc_p0  <= acc_nxt;
        bcnt_p0 <= bcnt_p0 + KW'(1);
      end
    end else if (!axiiv) begin
      vld_p1  <= 1'b0;
      bcnt_p0 <= '0;
      wcnt_p0 <= '0;
    end
  end

  // Stage p1 -> output: release the held word, or resolve a partial tail at frame end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      axiov    <= 1'b0;
      axiod    <= '0;
      axiolast <= 1'b0;
      axiokeep <= '0;
      axioerr  <= 1'b0;
    end else begin
      axiov    <= 1'b0;
      axiod    <= '0;
      axiolast <= 1'b0;
      axiokeep <= '0;
      axioerr  <= 1'b0;
      if (emit_full) begin
        axiov    <= 1'b1;
        axiod    <= hold_p1;
        axiolast <= !axiiv;
        axiokeep <= FULL_KEEP;
      end else if (partial) begin
`ifdef AGGREGATE_FLUSH_EN
        axiov    <= 1'b1;
        axiod    <= acc_p0;
        axiolast <= 1'b1;
        axiokeep <= bcnt_p0;
`else
        axioerr  <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_aggregate_param.sv
// tb_aggregate_param: drives four configurations of aggregate_param from a
// common beat stream and compares their outputs against a frame-level model.
module tb_aggregate_param;

`ifdef AGGREGATE_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  localparam int IW  [4] = '{2, 2, 2, 4};
  localparam int OW  [4] = '{32, 32, 32, 16};
  localparam int MSB [4] = '{1, 0, 1, 1};
  localparam int MW  [4] = '{0, 0, 1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iv;
  logic [3:0] id;
  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic ov0, ol0, oe0, ov1, ol1, oe1, ov2, ol2, oe2, ov3, ol3, oe3;
  logic [31:0] od0, od1, od2;
  logic [15:0] od3;
  logic [4:0]  ok0, ok1, ok2;
  logic [2:0]  ok3;

  aggregate_param u0 (.clk(clk), .rst(rst), .axiiv(iv), .axiid(id[1:0]), .axiov(ov0),
    .axiod(od0), .axiolast(ol0), .axiokeep(ok0), .axioerr(oe0));
  aggregate_param #(.FIRST_IN_MSB(0)) u1 (.clk(clk), .rst(rst), .axiiv(iv), .axiid(id[1:0]),
    .axiov(ov1), .axiod(od1), .axiolast(ol1), .axiokeep(ok1), .axioerr(oe1));
  aggregate_param #(.MAX_WORDS(1)) u2 (.clk(clk), .rst(rst), .axiiv(iv), .axiid(id[1:0]),
    .axiov(ov2), .axiod(od2), .axiolast(ol2), .axiokeep(ok2), .axioerr(oe2));
  aggregate_param #(.IN_W(4), .OUT_W(16)) u3 (.clk(clk), .rst(rst), .axiiv(iv), .axiid(id),
    .axiov(ov3), .axiod(od3), .axiolast(ol3), .axiokeep(ok3), .axioerr(oe3));

  typedef struct {
    logic [31:0] d;
    bit          last;
    int          keep;
    bit          err;
    int          cyc;
  } ev_t;

  ev_t obs_q[4][$];
  ev_t exp_q[4][$];
  int  stray[4];
  int  beats_q[$];
  int  last_edge, idle_edge;
  int  checks = 0;
  int  errors = 0;

  task automatic record(input int i, input logic v, input logic [31:0] d, input logic l,
                        input int k, input logic e);
    ev_t ev;
    if (v || e) begin
      ev.d = d; ev.last = l; ev.keep = k; ev.err = e; ev.cyc = cyc;
      obs_q[i].push_back(ev);
    end
    if (!v && (d != 0 || l || k != 0)) stray[i]++;
    if (v && e) stray[i]++;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      record(0, ov0, od0, ol0, int'(ok0), oe0);
      record(1, ov1, od1, ol1, int'(ok1), oe1);
      record(2, ov2, od2, ol2, int'(ok2), oe2);
      record(3, ov3, {16'h0, od3}, ol3, int'(ok3), oe3);
    end
  end

  // Frame-level reference: chunk the frame into words, apply the cap, resolve the tail.
  task automatic model(input int c, input int beats[$]);
    int  nb, n, words, rem, sh;
    ev_t ev;
    logic [31:0] v;
    nb = OW[c] / IW[c];
    n = beats.size();
    words = n / nb;
    rem = n % nb;
    if (MW[c] > 0 && words >= MW[c]) begin
      words = MW[c];
      rem = 0;
    end
    for (int w = 0; w < words + ((rem > 0) ? 1 : 0); w++) begin
      int cnt;
      cnt = (w < words) ? nb : rem;
      ev.d = 0; ev.cyc = 0; ev.err = 0;
      for (int j = 0; j < cnt; j++) begin
        v = 32'(beats[w * nb + j] & ((1 << IW[c]) - 1));
        sh = (MSB[c] != 0) ? (nb - 1 - j) * IW[c] : j * IW[c];
        ev.d |= v << sh;
      end
      ev.keep = cnt;
      ev.last = (w == words - 1 && rem == 0) || (w == words);
      if (w == words && !FLUSH) begin
        ev.d = 0; ev.last = 0; ev.keep = 0; ev.err = 1;
      end
      exp_q[c].push_back(ev);
    end
  endtask

  task automatic clear_all();
    for (int c = 0; c < 4; c++) begin
      obs_q[c].delete();
      exp_q[c].delete();
      stray[c] = 0;
    end
  endtask

  task automatic play(input int gap);
    foreach (beats_q[i]) begin
      @(negedge clk);
      iv = 1'b1;
      id = 4'(beats_q[i]);
      last_edge = cyc + 1;
    end
    @(negedge clk);
    iv = 1'b0;
    id = 4'h0;
    idle_edge = cyc + 1;
    for (int g = 1; g < gap; g++) @(negedge clk);
    for (int c = 0; c < 4; c++) model(c, beats_q);
  endtask

  task automatic idle(input int n);
    iv = 1'b0;
    id = 4'h0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; iv = 1'b0; id = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ov0, ol0, oe0, od0, ok0, ov3, ol3, oe3, od3, ok3} !== '0) begin
      errors++; $display("FAIL reset_state: got %h required 0", {ov0, ol0, oe0, od0, ok0});
    end
    rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); iv = 1'b1; id = 4'h3;
    end
    #2 rst = 1'b0;
    iv = 1'b0;
    #1;
    checks++;
    if ({ov0, ol0, oe0, od0, ok0} !== '0) begin
      errors++; $display("FAIL reset_midframe: got %h required 0", {ov0, ol0, oe0, od0, ok0});
    end
    @(negedge clk) rst = 1'b1;
    clear_all();
    beats_q.delete();
    for (int i = 0; i < 16; i++) beats_q.push_back(3);
    play(1);
    idle(4);
    checks++;
    if (obs_q[0].size() != 1) begin
      errors++; $display("FAIL reset_after_count: got %0d required 1", obs_q[0].size());
    end else if (obs_q[0][0].d !== 32'hFFFFFFFF || !obs_q[0][0].last || obs_q[0][0].keep != 16) begin
      errors++; $display("FAIL reset_after_word: got %h/%0d/%0d required ffffffff/1/16",
                         obs_q[0][0].d, obs_q[0][0].last, obs_q[0][0].keep);
    end
    checks++;
    if (stray[0] != 0) begin
      errors++; $display("FAIL reset_stray: got %0d required 0", stray[0]);
    end
    // Reset arriving while a word is on the outputs must clear them at once.
    play(1);
    @(posedge clk);
    #2;
    checks++;
    if (ov0 !== 1'b1) begin
      errors++; $display("FAIL reset_pre_valid: got %b required 1", ov0);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({ov0, ol0, od0, ok0} !== '0) begin
      errors++; $display("FAIL reset_async_clear: got %h required 0", {ov0, ol0, od0, ok0});
    end
    @(negedge clk) rst = 1'b1;
    idle(2);
  endtask

  task automatic test_latency();
    clear_all();
    beats_q.delete();
    for (int i = 0; i < 16; i++) beats_q.push_back(i % 4);
    play(1);
    idle(4);
    checks++;
    if (obs_q[0].size() != 1) begin
      errors++; $display("FAIL latency_count: got %0d required 1", obs_q[0].size());
    end else begin
      checks++;
      if (obs_q[0][0].d !== 32'h1B1B1B1B || !obs_q[0][0].last || obs_q[0][0].keep != 16) begin
        errors++; $display("FAIL latency_word: got %h/%0d/%0d required 1b1b1b1b/1/16",
                           obs_q[0][0].d, obs_q[0][0].last, obs_q[0][0].keep);
      end
      checks++;
      if (obs_q[0][0].cyc != last_edge + 1) begin
        errors++; $display("FAIL latency_cycle: got %0d required %0d", obs_q[0][0].cyc, last_edge + 1);
      end
    end
  endtask

  task automatic test_long_frame();
    logic [31:0] ed[5];
    bit          el[5];
    int          ek[5];
    bit          ee[5];
    ed = '{32'h1B1B1B1B, 32'h1B1B1B1B, 32'h0, 32'h0, 32'h0};
    el = '{0, 0, 0, 0, FLUSH};
    ek = '{16, 16, 16, 16, FLUSH ? 1 : 0};
    ee = '{0, 0, 0, 0, !FLUSH};
    clear_all();
    beats_q.delete();
    for (int i = 0; i < 32; i++) beats_q.push_back(i % 4);
    for (int i = 0; i < 33; i++) beats_q.push_back(0);
    play(1);
    idle(4);
    checks++;
    if (obs_q[0].size() != 5) begin
      errors++; $display("FAIL long_count: got %0d required 5", obs_q[0].size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (obs_q[0][i].d !== ed[i] || obs_q[0][i].last != el[i] || obs_q[0][i].keep != ek[i] ||
            obs_q[0][i].err != ee[i]) begin
          errors++; $display("FAIL long_word%0d: got %h/%0d/%0d/%0d required %h/%0d/%0d/%0d", i,
                             obs_q[0][i].d, obs_q[0][i].last, obs_q[0][i].keep, obs_q[0][i].err,
                             ed[i], el[i], ek[i], ee[i]);
        end
      end
      checks++;
      if (obs_q[0][4].cyc != idle_edge) begin
        errors++; $display("FAIL long_tail_cycle: got %0d required %0d", obs_q[0][4].cyc, idle_edge);
      end
    end
    checks++;
    if (obs_q[2].size() != 1) begin
      errors++; $display("FAIL cap_count: got %0d required 1", obs_q[2].size());
    end else begin
      checks++;
      if (obs_q[2][0].d !== 32'h1B1B1B1B || !obs_q[2][0].last || obs_q[2][0].keep != 16 ||
          obs_q[2][0].err || obs_q[2][0].cyc != idle_edge) begin
        errors++; $display("FAIL cap_word: got %h/%0d/%0d/%0d at %0d required 1b1b1b1b/1/16/0 at %0d",
                           obs_q[2][0].d, obs_q[2][0].last, obs_q[2][0].keep, obs_q[2][0].err,
                           obs_q[2][0].cyc, idle_edge);
      end
    end
  endtask

  task automatic test_lsb_first();
    clear_all();
    beats_q.delete();
    beats_q.push_back(1);
    for (int i = 0; i < 15; i++) beats_q.push_back(0);
    play(1);
    idle(4);
    checks++;
    if (obs_q[1].size() != 1) begin
      errors++; $display("FAIL lsb_count: got %0d required 1", obs_q[1].size());
    end else if (obs_q[1][0].d !== 32'h00000001 || !obs_q[1][0].last || obs_q[1][0].keep != 16) begin
      errors++; $display("FAIL lsb_word: got %h/%0d/%0d required 00000001/1/16",
                         obs_q[1][0].d, obs_q[1][0].last, obs_q[1][0].keep);
    end
  endtask

  task automatic test_narrow();
    clear_all();
    beats_q = '{1, 2, 3, 4};
    play(1);
    play(1);
    idle(4);
    checks++;
    if (obs_q[3].size() != 2) begin
      errors++; $display("FAIL narrow_count: got %0d required 2", obs_q[3].size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_q[3][i].d !== 32'h1234 || !obs_q[3][i].last || obs_q[3][i].keep != 4) begin
          errors++; $display("FAIL narrow_word%0d: got %h/%0d/%0d required 1234/1/4", i,
                             obs_q[3][i].d, obs_q[3][i].last, obs_q[3][i].keep);
        end
      end
    end
  endtask

  task automatic test_random();
    clear_all();
    for (int f = 0; f < 25; f++) begin
      int n;
      n = $urandom_range(1, 70);
      beats_q.delete();
      for (int i = 0; i < n; i++) beats_q.push_back($urandom_range(0, 15));
      play($urandom_range(1, 3));
    end
    idle(4);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (obs_q[c].size() != exp_q[c].size()) begin
        errors++; $display("FAIL rand_count dut%0d: got %0d required %0d", c,
                           obs_q[c].size(), exp_q[c].size());
      end
      for (int i = 0; i < obs_q[c].size() && i < exp_q[c].size(); i++) begin
        checks++;
        if (obs_q[c][i].d !== exp_q[c][i].d || obs_q[c][i].last != exp_q[c][i].last ||
            obs_q[c][i].keep != exp_q[c][i].keep || obs_q[c][i].err != exp_q[c][i].err) begin
          errors++; $display("FAIL rand_word dut%0d #%0d: got %h/%0d/%0d/%0d required %h/%0d/%0d/%0d",
                             c, i, obs_q[c][i].d, obs_q[c][i].last, obs_q[c][i].keep, obs_q[c][i].err,
                             exp_q[c][i].d, exp_q[c][i].last, exp_q[c][i].keep, exp_q[c][i].err);
        end
      end
      checks++;
      if (stray[c] != 0) begin
        errors++; $display("FAIL rand_stray dut%0d: got %0d required 0", c, stray[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_long_frame();
    test_lsb_first();
    test_narrow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
